// File: rtl/laser_tx_serializer.sv
// Laser transmit framer: pops bytes from the drop queue and sends each as an
// on/off-keyed 10-bit frame (start=1, 8 data bits LSB first, stop=0), with each
// bit held for CLKS_PER_BIT clocks. All outputs come straight from registers.
module laser_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        clear,
  input  logic [7:0]  q_data,
  input  logic        q_empty,
  output logic        q_read,
  output logic        laser_out,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] bytes_sent
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StStart,
    StData,
    StStop
  } state_e;

  state_e          state_q;
  logic [7:0]      sh_q;
  logic [2:0]      bit_cnt_q;
  logic [CntW-1:0] cyc_cnt_q;
  logic [15:0]     bytes_q;
  logic            read_q;
  logic            laser_q;
  logic            busy_q;
  logic            done_q;

  wire slot_end = (cyc_cnt_q == CntLast);
  wire can_fetch = enable && !q_empty;

  // Frame sequencer; outputs are registered alongside the state they belong to.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      cyc_cnt_q <= '0;
      bytes_q   <= '0;
      read_q    <= 1'b0;
      laser_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // Strobes default low; only set on the transitions that need them.
      read_q <= 1'b0;
      done_q <= 1'b0;
      if (clear) begin
        // Abort: a byte already popped is simply dropped, the frame count is kept.
        state_q   <= StIdle;
        sh_q      <= '0;
        bit_cnt_q <= '0;
        cyc_cnt_q <= '0;
        laser_q   <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            laser_q <= 1'b0;
            busy_q  <= 1'b0;
            if (can_fetch) begin
              state_q <= StFetch;
              read_q  <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
          StFetch: begin
            // The queue pops on this edge, so capture its head now.
            sh_q      <= q_data;
            cyc_cnt_q <= '0;
            laser_q   <= 1'b1;
            state_q   <= StStart;
          end
          StStart: begin
            if (slot_end) begin
              cyc_cnt_q <= '0;
              bit_cnt_q <= '0;
              laser_q   <= sh_q[0];
              state_q   <= StData;
            end else begin
              cyc_cnt_q <= cyc_cnt_q + CntW'(1);
            end
          end
          StData: begin
            if (slot_end) begin
              cyc_cnt_q <= '0;
              sh_q      <= {1'b0, sh_q[7:1]};
              if (bit_cnt_q == 3'd7) begin
                laser_q <= 1'b0;
                state_q <= StStop;
              end else begin
                // Next bit is the one about to be shifted into sh_q[0].
                laser_q   <= sh_q[1];
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end else begin
              cyc_cnt_q <= cyc_cnt_q + CntW'(1);
            end
          end
          StStop: begin
            if (slot_end) begin
              cyc_cnt_q <= '0;
              bytes_q   <= bytes_q + 16'd1;
              done_q    <= 1'b1;
              if (can_fetch) begin
                state_q <= StFetch;
                read_q  <= 1'b1;
              end else begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end
            end else begin
              cyc_cnt_q <= cyc_cnt_q + CntW'(1);
            end
          end
          default: begin
            state_q <= StIdle;
            laser_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign q_read     = read_q;
  assign laser_out  = laser_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign bytes_sent = bytes_q;

endmodule

// File: tb/tb_laser_tx_serializer.sv
// Bench for laser_tx_serializer: a byte-queue model feeds the DUT, a scoreboard
// holds the bytes expected on the laser line, and frames are checked slot by slot.
module tb_laser_tx_serializer;

  localparam int Cpb = 4;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic        clear;
  logic [7:0]  q_data;
  logic        q_empty;
  logic        q_read;
  logic        laser_out;
  logic        busy;
  logic        frame_done;
  logic [15:0] bytes_sent;

  laser_tx_serializer #(.CLKS_PER_BIT(Cpb)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .clear      (clear),
    .q_data     (q_data),
    .q_empty    (q_empty),
    .q_read     (q_read),
    .laser_out  (laser_out),
    .busy       (busy),
    .frame_done (frame_done),
    .bytes_sent (bytes_sent)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] pat;  // bit i = laser level in slot i (slot 0 = start bit)
  } vec_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc_cnt = 0;
  int          last_fetch = 0;
  logic [15:0] exp_sent = 16'd0;
  logic [7:0]  fifo[$];
  logic [7:0]  exp_bytes[$];
  vec_t        vecs[4];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic sync_q();
    q_empty = (fifo.size() == 0);
    q_data  = q_empty ? 8'h00 : fifo[0];
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo.push_back(b);
    exp_bytes.push_back(b);
    sync_q();
  endtask

  // Queue model: pops just after the edge that ends the q_read cycle.
  always @(posedge clock) begin
    if (q_read) begin
      check("pop from empty queue", {31'd0, q_empty}, 32'd0);
      #1;
      if (fifo.size() > 0) void'(fifo.pop_front());
      sync_q();
    end
  end

  // Waits for a fetch, then samples every cycle of the frame. Returns at the
  // negedge of the frame_done cycle, or just after a clear-induced abort.
  task automatic run_frame(input string tag, input logic [9:0] pat, input int drop_slot,
                           input int clear_slot);
    int         waited;
    logic [9:0] got;
    logic [7:0] b;
    bit         bad_read;
    bit         bad_hold;
    bit         aborted;
    waited = 0;
    while (!q_read && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    if (!q_read) begin
      check({tag, " fetch timeout"}, 32'd0, 32'd1);
      return;
    end
    last_fetch = cyc_cnt;
    b = (exp_bytes.size() > 0) ? exp_bytes.pop_front() : 8'h00;
    check({tag, " fetch laser"}, {31'd0, laser_out}, 32'd0);
    check({tag, " fetch busy"}, {31'd0, busy}, 32'd1);
    got      = '0;
    bad_read = 1'b0;
    bad_hold = 1'b0;
    aborted  = 1'b0;
    for (int s = 0; s < 10; s++) begin
      for (int c = 0; c < Cpb; c++) begin
        @(negedge clock);
        if (s == drop_slot && c == 0) enable = 1'b0;
        if (s == clear_slot && c == 1) begin
          clear = 1'b1;
          @(negedge clock);
          clear = 1'b0;
          check({tag, " clear laser"}, {31'd0, laser_out}, 32'd0);
          check({tag, " clear busy"}, {31'd0, busy}, 32'd0);
          check({tag, " clear q_read"}, {31'd0, q_read}, 32'd0);
          check({tag, " clear frame_done"}, {31'd0, frame_done}, 32'd0);
          check({tag, " clear bytes_sent"}, {16'd0, bytes_sent}, {16'd0, exp_sent});
          aborted = 1'b1;
          break;
        end
        if (q_read) bad_read = 1'b1;
        if (c == 0) got[s] = laser_out;
        else if (laser_out !== got[s]) bad_hold = 1'b1;
      end
      if (aborted) break;
    end
    if (aborted) return;
    check({tag, " slot pattern"}, {22'd0, got}, {22'd0, pat});
    check({tag, " scoreboard byte"}, {24'd0, got[8:1]}, {24'd0, b});
    check({tag, " level steady in slot"}, {31'd0, bad_hold}, 32'd0);
    check({tag, " no q_read in frame"}, {31'd0, bad_read}, 32'd0);
    @(negedge clock);
    exp_sent = exp_sent + 16'd1;
    check({tag, " frame_done"}, {31'd0, frame_done}, 32'd1);
    check({tag, " bytes_sent"}, {16'd0, bytes_sent}, {16'd0, exp_sent});
  endtask

  initial begin
    int   t1;
    bit   bad;
    logic [7:0] bb;

    vecs[0] = '{data: 8'hA5, pat: 10'b0101001011};
    vecs[1] = '{data: 8'h5A, pat: 10'b0010110101};
    vecs[2] = '{data: 8'h81, pat: 10'b0100000011};
    vecs[3] = '{data: 8'h3C, pat: 10'b0001111001};

    reset_n = 1'b0;
    enable  = 1'b0;
    clear   = 1'b0;
    sync_q();
    repeat (3) @(negedge clock);
    check("reset q_read", {31'd0, q_read}, 32'd0);
    check("reset laser", {31'd0, laser_out}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset frame_done", {31'd0, frame_done}, 32'd0);
    check("reset bytes_sent", {16'd0, bytes_sent}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    enable = 1'b1;

    // Single isolated frames
    for (int i = 0; i < 4; i++) begin
      push_byte(vecs[i].data);
      run_frame("single", vecs[i].pat, -1, -1);
      check("single idle busy", {31'd0, busy}, 32'd0);
    end

    // Back-to-back frames
    push_byte(8'h00);
    push_byte(8'hFF);
    run_frame("b2b0", 10'b0000000001, -1, -1);
    t1 = last_fetch;
    run_frame("b2b1", 10'b0111111111, -1, -1);
    check("b2b fetch spacing", last_fetch - t1, 32'd41);
    check("b2b idle busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    check("b2b no refetch", {31'd0, q_read}, 32'd0);

    // Enable dropped during frame data
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    run_frame("drop", {1'b0, 8'h11, 1'b1}, 3, -1);
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (q_read || busy) bad = 1'b1;
    end
    check("drop stays idle", {31'd0, bad}, 32'd0);
    check("drop queue left", fifo.size(), 32'd2);
    enable = 1'b1;
    run_frame("resume0", {1'b0, 8'h22, 1'b1}, -1, -1);
    run_frame("resume1", {1'b0, 8'h33, 1'b1}, -1, -1);

    // Clear during data bit 3, next queued byte follows
    push_byte(8'h3C);
    push_byte(8'h96);
    run_frame("clear", vecs[3].pat, -1, 4);
    run_frame("after clear", {1'b0, 8'h96, 1'b1}, -1, -1);

    // Counter wrap
    @(negedge clock);
    force dut.bytes_q = 16'hFFFF;
    #1;
    release dut.bytes_q;
    exp_sent = 16'hFFFF;
    @(negedge clock);
    check("wrap preload", {16'd0, bytes_sent}, 32'h0000FFFF);
    push_byte(8'h81);
    run_frame("wrap", vecs[2].pat, -1, -1);

    // Asynchronous reset in the middle of data bits
    push_byte(8'h5A);
    t1 = 0;
    while (!q_read && t1 < 100) begin
      @(negedge clock);
      t1++;
    end
    check("mid reset fetch seen", {31'd0, q_read}, 32'd1);
    if (exp_bytes.size() > 0) bb = exp_bytes.pop_front();
    repeat (10) @(negedge clock);
    check("mid reset in frame", {31'd0, busy}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("async reset laser", {31'd0, laser_out}, 32'd0);
    check("async reset busy", {31'd0, busy}, 32'd0);
    check("async reset bytes_sent", {16'd0, bytes_sent}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    exp_sent = 16'd0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (q_read || laser_out || busy || frame_done) bad = 1'b1;
    end
    check("post reset quiet", {31'd0, bad}, 32'd0);
    check("post reset bytes_sent", {16'd0, bytes_sent}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
